// File: rtl/csm_mul8_sequencer_if.sv
// Operand/product handshake and 4x4 array bus between a requester and csm_mul8_sequencer.
// The requester side also hosts the shared combinational 4x4 array (mul_a/mul_b -> mul_p).
interface csm_mul8_sequencer_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic        sgn;
   logic [3:0]  mul_a;
   logic [3:0]  mul_b;
   logic [7:0]  mul_p;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_prod;
   logic        busy;

   modport master (
      output in_valid, in_a, in_b, sgn, mul_p, out_ready,
      input  in_ready, mul_a, mul_b, out_valid, out_prod, busy
   );

   modport slave (
      input  in_valid, in_a, in_b, sgn, mul_p, out_ready,
      output in_ready, mul_a, mul_b, out_valid, out_prod, busy
   );
endinterface

// File: rtl/csm_mul8_sequencer.sv
// 8x8 multiply built from four nibble passes through one shared external 4x4 array,
// with magnitude/sign handling for two's complement operands.
module csm_mul8_sequencer #(
   parameter bit SIGNED_EN = 1'b1
) (
   input logic            clk,
   input logic            rst_n,
   csm_mul8_sequencer_if.slave bus
);

   localparam int unsigned OP_W   = 8;
   localparam int unsigned NIB_W  = 4;
   localparam int unsigned PROD_W = 16;
   localparam int unsigned STEP_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic [PROD_W-1:0]   acc_q, acc_d;
   logic [OP_W-1:0]     a_q, a_d;
   logic [OP_W-1:0]     b_q, b_d;
   logic                neg_q, neg_d;
   logic [NIB_W-1:0]    mul_a_q, mul_a_d;
   logic [NIB_W-1:0]    mul_b_q, mul_b_d;
   logic [PROD_W-1:0]   out_prod_q, out_prod_d;
   logic                out_valid_q, out_valid_d;
   logic                in_ready_q, in_ready_d;
   logic                busy_q, busy_d;

   logic                signed_op_c;
   logic [OP_W-1:0]     a_abs_c, b_abs_c;
   logic [PROD_W-1:0]   pp_c, acc_sum_c;

   // Operand magnitudes; |-128| fits as unsigned 128.
   always_comb begin
      signed_op_c = SIGNED_EN && bus.sgn;
      a_abs_c     = (signed_op_c && bus.in_a[OP_W-1]) ? OP_W'(-bus.in_a) : bus.in_a;
      b_abs_c     = (signed_op_c && bus.in_b[OP_W-1]) ? OP_W'(-bus.in_b) : bus.in_b;
   end

   // Partial product weighted by the nibble positions of the current step.
   always_comb begin
      pp_c = PROD_W'(bus.mul_p);
      case (step_q)
         2'd0:    pp_c = PROD_W'(bus.mul_p);
         2'd1,
         2'd2:    pp_c = PROD_W'(bus.mul_p) << NIB_W;
         default: pp_c = PROD_W'(bus.mul_p) << (2 * NIB_W);
      endcase
      acc_sum_c = acc_q + pp_c;
   end

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      acc_d       = acc_q;
      a_d         = a_q;
      b_d         = b_q;
      neg_d       = neg_q;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      out_prod_d  = out_prod_q;
      out_valid_d = out_valid_q;

      case (state_q)
         IDLE: begin
            mul_a_d = '0;
            mul_b_d = '0;
            if (bus.in_valid && in_ready_q) begin
               a_d     = a_abs_c;
               b_d     = b_abs_c;
               neg_d   = signed_op_c && (bus.in_a[OP_W-1] ^ bus.in_b[OP_W-1]);
               acc_d   = '0;
               step_d  = '0;
               mul_a_d = a_abs_c[NIB_W-1:0];
               mul_b_d = b_abs_c[NIB_W-1:0];
               state_d = CALC;
            end
         end

         CALC: begin
            acc_d  = acc_sum_c;
            step_d = step_q + 2'd1;
            // Present the nibble pair for the following step.
            case (step_q)
               2'd0: begin
                  mul_a_d = a_q[OP_W-1:NIB_W];
                  mul_b_d = b_q[NIB_W-1:0];
               end
               2'd1: begin
                  mul_a_d = a_q[NIB_W-1:0];
                  mul_b_d = b_q[OP_W-1:NIB_W];
               end
               2'd2: begin
                  mul_a_d = a_q[OP_W-1:NIB_W];
                  mul_b_d = b_q[OP_W-1:NIB_W];
               end
               default: begin
                  mul_a_d     = '0;
                  mul_b_d     = '0;
                  out_prod_d  = neg_q ? PROD_W'(-acc_sum_c) : acc_sum_c;
                  out_valid_d = 1'b1;
                  state_d     = DONE;
               end
            endcase
         end

         DONE: begin
            mul_a_d = '0;
            mul_b_d = '0;
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            mul_a_d     = '0;
            mul_b_d     = '0;
         end
      endcase

      in_ready_d = (state_d == IDLE);
      busy_d     = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         step_q      <= '0;
         acc_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         neg_q       <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         out_prod_q  <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         acc_q       <= acc_d;
         a_q         <= a_d;
         b_q         <= b_d;
         neg_q       <= neg_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         out_prod_q  <= out_prod_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.busy      = busy_q;
   assign bus.mul_a     = mul_a_q;
   assign bus.mul_b     = mul_b_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_prod  = out_prod_q;

endmodule
